// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and constants for the IceStick UART echo design.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_BUSY = 2'd2
    } sched_state_e;

    localparam logic [7:0] ASCII_CR          = 8'h0D;
    localparam logic [7:0] ASCII_LF          = 8'h0A;
    localparam int         UART_CLKS_PER_BIT = 104;

    localparam logic GRANT_FIFO = 1'b0;
    localparam logic GRANT_HOST = 1'b1;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with show-ahead read data and occupancy.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_pop_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int                  c_AW    = $clog2(DEPTH);
    localparam logic [c_AW:0]       c_FULL  = (c_AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic             w_pop_ok;
    logic             w_push_ok;

    assign w_pop_ok  = i_pop && (r_count != '0);
    // A full FIFO still takes a push when a slot frees in the same cycle.
    assign w_push_ok = i_push && ((r_count != c_FULL) || w_pop_ok);

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_pop_data = r_mem[r_rd_ptr];
    assign o_full     = (r_count == c_FULL);
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;

endmodule
`default_nettype wire

// File: rtl/uart_echo_sched.sv
`default_nettype none
// ============================================================================
// Module      : uart_echo_sched
// Description : Shares one uart_tx between echoed rx bytes and host requests.
//               Optional CR->CRLF expansion when UART_ECHO_SCHED_CRLF_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_echo_sched
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          hwclk,
    input  logic                          rst,
    input  logic                          rx_dv,
    input  logic [7:0]                    rx_byte,
    input  logic                          req_valid,
    input  logic [7:0]                    req_byte,
    output logic                          req_ready,
    output logic                          tx_dv,
    output logic [7:0]                    tx_byte,
    input  logic                          tx_active,
    input  logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam logic [1:0] c_ST_IDLE = ST_IDLE;
    localparam logic [1:0] c_ST_LOAD = ST_LOAD;
    localparam logic [1:0] c_ST_BUSY = ST_BUSY;

    logic [1:0] r_state;
    logic [7:0] r_tx_byte;
    logic       r_last_grant;
    logic       r_req_seen;
    logic       r_overflow;

    logic [7:0] w_fifo_data;
    logic       w_fifo_full;
    logic       w_fifo_empty;
    logic       w_fifo_pend;
    logic       w_host_pend;
    logic       w_lf_pend;
    logic       w_can_grant;
    logic       w_grant_lf;
    logic       w_grant_fifo;
    logic       w_grant_host;
    logic       w_grant_any;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_echo_fifo (
        .clk         (hwclk),
        .rst         (rst),
        .i_push      (rx_dv),
        .i_push_data (rx_byte),
        .i_pop       (w_grant_fifo),
        .o_pop_data  (w_fifo_data),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_count     (fifo_count)
    );

`ifdef UART_ECHO_SCHED_CRLF_EN
    logic r_lf_pend;

    always_ff @(posedge hwclk) begin
        if (rst) begin
            r_lf_pend <= 1'b0;
        end else if (w_grant_lf) begin
            r_lf_pend <= 1'b0;
        end else if (w_grant_fifo && (w_fifo_data == ASCII_CR)) begin
            r_lf_pend <= 1'b1;
        end
    end

    assign w_lf_pend = r_lf_pend;
`else
    assign w_lf_pend = 1'b0;
`endif

    // The host request is seen one cycle late so both sources reach tx_dv
    // two cycles after their input event; cleared on accept so a new byte
    // is never confused with the one just taken.
    always_ff @(posedge hwclk) begin
        if (rst || w_grant_host) begin
            r_req_seen <= 1'b0;
        end else begin
            r_req_seen <= req_valid;
        end
    end

    assign w_fifo_pend = !w_fifo_empty;
    assign w_host_pend = req_valid && r_req_seen;
    assign w_can_grant = (r_state == c_ST_IDLE) && !tx_active;

    always_comb begin
        w_grant_lf   = 1'b0;
        w_grant_fifo = 1'b0;
        w_grant_host = 1'b0;
        if (w_can_grant) begin
            if (w_lf_pend) begin
                w_grant_lf = 1'b1;
            end else if (w_fifo_pend && w_host_pend) begin
                if (r_last_grant == GRANT_HOST) begin
                    w_grant_fifo = 1'b1;
                end else begin
                    w_grant_host = 1'b1;
                end
            end else if (w_fifo_pend) begin
                w_grant_fifo = 1'b1;
            end else if (w_host_pend) begin
                w_grant_host = 1'b1;
            end
        end
    end

    assign w_grant_any = w_grant_lf || w_grant_fifo || w_grant_host;

    always_ff @(posedge hwclk) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_tx_byte    <= 8'h00;
            r_last_grant <= GRANT_HOST;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_grant_any) begin
                        r_state <= c_ST_LOAD;
                        if (w_grant_lf) begin
                            r_tx_byte <= ASCII_LF;
                        end else if (w_grant_fifo) begin
                            r_tx_byte    <= w_fifo_data;
                            r_last_grant <= GRANT_FIFO;
                        end else begin
                            r_tx_byte    <= req_byte;
                            r_last_grant <= GRANT_HOST;
                        end
                    end
                end
                c_ST_LOAD: begin
                    r_state <= c_ST_BUSY;
                end
                c_ST_BUSY: begin
                    if (tx_done) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge hwclk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (rx_dv && w_fifo_full && !w_grant_fifo) begin
            r_overflow <= 1'b1;
        end
    end

    assign req_ready = w_grant_host;
    assign tx_dv     = (r_state == c_ST_LOAD);
    assign tx_byte   = r_tx_byte;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_uart_echo_sched.sv
`timescale 1ns/1ps
// Directed bench for uart_echo_sched: per-cycle vector table plus
// sequences for overflow, full push/pop, reset mid-frame and CR handling.
module tb_uart_echo_sched;

    logic       hwclk = 1'b0;
    logic       rst;
    logic       rx_dv;
    logic [7:0] rx_byte;
    logic       req_valid;
    logic [7:0] req_byte;
    logic       req_ready;
    logic       tx_dv;
    logic [7:0] tx_byte;
    logic       tx_active;
    logic       tx_done;
    logic [3:0] fifo_count;
    logic       overflow;

    logic       tb_act;
    logic       tb_done;
    logic       model_en;
    logic       model_act;
    logic       model_done;
    int         model_cnt;
    logic [7:0] sent_q[$];

    int vectors     = 0;
    int miscompares = 0;

    always #5 hwclk = ~hwclk;

    assign tx_active = model_en ? model_act  : tb_act;
    assign tx_done   = model_en ? model_done : tb_done;

    uart_echo_sched #(.FIFO_DEPTH(8)) dut (
        .hwclk      (hwclk),
        .rst        (rst),
        .rx_dv      (rx_dv),
        .rx_byte    (rx_byte),
        .req_valid  (req_valid),
        .req_byte   (req_byte),
        .req_ready  (req_ready),
        .tx_dv      (tx_dv),
        .tx_byte    (tx_byte),
        .tx_active  (tx_active),
        .tx_done    (tx_done),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    // Short-frame stand-in for uart_tx: records every issued byte.
    always @(negedge hwclk) begin
        if (!model_en) begin
            model_act  = 1'b0;
            model_done = 1'b0;
            model_cnt  = 0;
        end else begin
            model_done = 1'b0;
            if (tx_dv) begin
                sent_q.push_back(tx_byte);
                model_act = 1'b1;
                model_cnt = 3;
            end else if (model_cnt > 0) begin
                model_cnt = model_cnt - 1;
                if (model_cnt == 0) begin
                    model_done = 1'b1;
                    model_act  = 1'b0;
                end
            end
        end
    end

    typedef struct {
        logic       r;
        logic       dv;
        logic [7:0] rb;
        logic       rv;
        logic [7:0] hb;
        logic       act;
        logic       dn;
        logic       e_dv;
        logic [7:0] e_b;
        logic       e_rdy;
        logic [3:0] e_cnt;
        logic       e_ovf;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic r, input logic dv, input logic [7:0] rb,
                                input logic rv, input logic [7:0] hb, input logic act,
                                input logic dn, input logic e_dv, input logic [7:0] e_b,
                                input logic e_rdy, input logic [3:0] e_cnt, input logic e_ovf);
        vec_t v;
        v.r = r; v.dv = dv; v.rb = rb; v.rv = rv; v.hb = hb; v.act = act; v.dn = dn;
        v.e_dv = e_dv; v.e_b = e_b; v.e_rdy = e_rdy; v.e_cnt = e_cnt; v.e_ovf = e_ovf;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset(input logic act);
        @(posedge hwclk); #1;
        rst = 1'b1; rx_dv = 1'b0; req_valid = 1'b0; tb_done = 1'b0;
        model_en = 1'b0; tb_act = act;
        @(posedge hwclk); #1;
        rst = 1'b0;
    endtask

    // Runs cycles until n bytes were issued; retires host requests on accept.
    task automatic wait_bytes(input int n, input int limit);
        int k;
        k = 0;
        while (sent_q.size() < n && k < limit) begin
            @(negedge hwclk); #2;
            if (req_ready) begin
                @(posedge hwclk); #1;
                req_valid = 1'b0;
            end
            k++;
        end
        chk("wait_bytes_in_time", 32'(sent_q.size() >= n), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen_dv;
        int   n_exp;
        rst = 1'b1; rx_dv = 1'b0; rx_byte = 8'h00; req_valid = 1'b0; req_byte = 8'h00;
        tb_act = 1'b0; tb_done = 1'b0; model_en = 1'b0;

        //         r dv rb    rv hb    act dn | dv b     rdy cnt ovf
        vt.push_back(mk(1,0,8'h00,0,8'h00,0,0, 0,8'h00,0,0,0));
        vt.push_back(mk(0,1,8'h41,0,8'h00,0,0, 0,8'h00,0,0,0));
        vt.push_back(mk(0,0,8'h00,0,8'h00,0,0, 0,8'h00,0,1,0));
        vt.push_back(mk(0,0,8'h00,0,8'h00,0,0, 1,8'h41,0,0,0));
        vt.push_back(mk(0,0,8'h00,0,8'h00,1,0, 0,8'h41,0,0,0));
        vt.push_back(mk(0,0,8'h00,0,8'h00,1,1, 0,8'h41,0,0,0));
        vt.push_back(mk(0,0,8'h00,0,8'h00,0,1, 0,8'h41,0,0,0));
        vt.push_back(mk(0,0,8'h00,1,8'h55,0,0, 0,8'h41,0,0,0));
        vt.push_back(mk(0,0,8'h00,1,8'h55,0,0, 0,8'h41,1,0,0));
        vt.push_back(mk(0,0,8'h00,0,8'h00,0,0, 1,8'h55,0,0,0));
        vt.push_back(mk(0,0,8'h00,0,8'h00,1,0, 0,8'h55,0,0,0));
        vt.push_back(mk(0,0,8'h00,0,8'h00,1,1, 0,8'h55,0,0,0));
        vt.push_back(mk(0,0,8'h00,0,8'h00,0,0, 0,8'h55,0,0,0));
        vt.push_back(mk(1,0,8'h00,0,8'h00,0,0, 0,8'h55,0,0,0));
        vt.push_back(mk(0,1,8'h01,1,8'h02,1,0, 0,8'h00,0,0,0));
        vt.push_back(mk(0,0,8'h00,1,8'h02,1,0, 0,8'h00,0,1,0));
        vt.push_back(mk(0,0,8'h00,1,8'h02,0,0, 0,8'h00,0,1,0));
        vt.push_back(mk(0,1,8'h03,1,8'h02,0,0, 1,8'h01,0,0,0));
        vt.push_back(mk(0,0,8'h00,1,8'h02,1,0, 0,8'h01,0,1,0));
        vt.push_back(mk(0,0,8'h00,1,8'h02,1,1, 0,8'h01,0,1,0));
        vt.push_back(mk(0,0,8'h00,1,8'h02,0,0, 0,8'h01,1,1,0));
        vt.push_back(mk(0,0,8'h00,1,8'h04,0,0, 1,8'h02,0,1,0));
        vt.push_back(mk(0,0,8'h00,1,8'h04,1,0, 0,8'h02,0,1,0));
        vt.push_back(mk(0,0,8'h00,1,8'h04,1,1, 0,8'h02,0,1,0));
        vt.push_back(mk(0,0,8'h00,1,8'h04,0,0, 0,8'h02,0,1,0));
        vt.push_back(mk(0,0,8'h00,1,8'h04,0,0, 1,8'h03,0,0,0));
        vt.push_back(mk(0,0,8'h00,1,8'h04,1,0, 0,8'h03,0,0,0));
        vt.push_back(mk(0,0,8'h00,1,8'h04,1,1, 0,8'h03,0,0,0));
        vt.push_back(mk(0,0,8'h00,1,8'h04,0,0, 0,8'h03,1,0,0));
        vt.push_back(mk(0,1,8'h05,0,8'h00,0,1, 1,8'h04,0,0,0));
        vt.push_back(mk(0,0,8'h00,0,8'h00,0,0, 0,8'h04,0,1,0));
        vt.push_back(mk(0,0,8'h00,0,8'h00,0,1, 0,8'h04,0,1,0));
        vt.push_back(mk(0,0,8'h00,0,8'h00,0,0, 0,8'h04,0,1,0));
        vt.push_back(mk(0,0,8'h00,0,8'h00,0,0, 1,8'h05,0,0,0));
        vt.push_back(mk(0,0,8'h00,0,8'h00,0,1, 0,8'h05,0,0,0));
        vt.push_back(mk(0,0,8'h00,0,8'h00,0,0, 0,8'h05,0,0,0));

        repeat (3) @(posedge hwclk);

        for (int i = 0; i < vt.size(); i++) begin
            @(posedge hwclk); #1;
            rst = vt[i].r; rx_dv = vt[i].dv; rx_byte = vt[i].rb;
            req_valid = vt[i].rv; req_byte = vt[i].hb;
            tb_act = vt[i].act; tb_done = vt[i].dn;
            @(negedge hwclk);
            vectors++;
            if ({tx_dv, tx_byte, req_ready, fifo_count, overflow} !==
                {vt[i].e_dv, vt[i].e_b, vt[i].e_rdy, vt[i].e_cnt, vt[i].e_ovf}) begin
                miscompares++;
                $display("FAIL vec%0d: got dv=%0b byte=%02h rdy=%0b cnt=%0d ovf=%0b, expected dv=%0b byte=%02h rdy=%0b cnt=%0d ovf=%0b",
                         i, tx_dv, tx_byte, req_ready, fifo_count, overflow,
                         vt[i].e_dv, vt[i].e_b, vt[i].e_rdy, vt[i].e_cnt, vt[i].e_ovf);
            end
        end

        // Overflow: nine pushes against a stalled line.
        do_reset(1'b1);
        for (int i = 0; i < 9; i++) begin
            @(posedge hwclk); #1;
            rx_dv = 1'b1; rx_byte = 8'(8'h10 + i);
        end
        @(posedge hwclk); #1;
        rx_dv = 1'b0;
        @(negedge hwclk);
        chk("ovf_count", 32'(fifo_count), 32'd8);
        chk("ovf_flag", 32'(overflow), 32'd1);
        @(posedge hwclk); #1;
        sent_q.delete(); model_en = 1'b1;
        wait_bytes(8, 300);
        repeat (30) @(posedge hwclk);
        chk("ovf_sent_len", 32'(sent_q.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk("ovf_byte", 32'(sent_q[i]), 32'h10 + 32'(i));
        end
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // Reset mid-frame with three bytes queued behind the active frame.
        @(posedge hwclk); #1;
        model_en = 1'b0; tb_act = 1'b0; sent_q.delete();
        rx_dv = 1'b1; rx_byte = 8'h30;
        @(posedge hwclk); #1;
        rx_dv = 1'b0;
        @(posedge hwclk); #1;
        tb_act = 1'b1; rx_dv = 1'b1; rx_byte = 8'h31;
        @(posedge hwclk); #1;
        rx_byte = 8'h32;
        @(posedge hwclk); #1;
        rx_byte = 8'h33;
        @(posedge hwclk); #1;
        rx_dv = 1'b0;
        @(negedge hwclk);
        chk("mid_count", 32'(fifo_count), 32'd3);
        chk("mid_tx_byte", 32'(tx_byte), 32'h30);
        @(posedge hwclk); #1;
        rst = 1'b1; req_valid = 1'b1; req_byte = 8'h5A;
        @(posedge hwclk); #1;
        rst = 1'b0;
        @(negedge hwclk);
        chk("rst_tx_dv", 32'(tx_dv), 32'd0);
        chk("rst_tx_byte", 32'(tx_byte), 32'h00);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_fifo_count", 32'(fifo_count), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        seen_dv = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge hwclk);
            seen_dv = seen_dv | tx_dv | req_ready;
        end
        chk("rst_no_issue_while_active", 32'(seen_dv), 32'd0);
        @(posedge hwclk); #1;
        model_en = 1'b1;
        wait_bytes(1, 100);
        repeat (20) @(posedge hwclk);
        chk("rst_first_after_release", 32'(sent_q[0]), 32'h5A);
        chk("rst_sent_len", 32'(sent_q.size()), 32'd1);

        // Push and pop in the same cycle on a full FIFO.
        do_reset(1'b1);
        for (int i = 0; i < 8; i++) begin
            @(posedge hwclk); #1;
            rx_dv = 1'b1; rx_byte = 8'(8'h20 + i);
        end
        @(posedge hwclk); #1;
        rx_dv = 1'b0;
        @(negedge hwclk);
        chk("full_count", 32'(fifo_count), 32'd8);
        @(posedge hwclk); #1;
        sent_q.delete(); model_en = 1'b1;
        rx_dv = 1'b1; rx_byte = 8'h28;
        @(posedge hwclk); #1;
        rx_dv = 1'b0;
        @(negedge hwclk);
        chk("pushpop_count", 32'(fifo_count), 32'd8);
        chk("pushpop_overflow", 32'(overflow), 32'd0);
        wait_bytes(9, 400);
        repeat (20) @(posedge hwclk);
        for (int i = 0; i < 9; i++) begin
            chk("pushpop_byte", 32'(sent_q[i]), 32'h20 + 32'(i));
        end

        // CR echo with a host byte waiting.
        do_reset(1'b1);
        @(posedge hwclk); #1;
        rx_dv = 1'b1; rx_byte = 8'h0D; req_valid = 1'b1; req_byte = 8'h77;
        @(posedge hwclk); #1;
        rx_dv = 1'b0;
        @(posedge hwclk); #1;
        sent_q.delete(); model_en = 1'b1;
`ifdef UART_ECHO_SCHED_CRLF_EN
        n_exp = 3;
`else
        n_exp = 2;
`endif
        wait_bytes(n_exp, 300);
        repeat (40) @(posedge hwclk);
        chk("cr_sent_len", 32'(sent_q.size()), 32'(n_exp));
        chk("cr_first", 32'(sent_q[0]), 32'h0D);
`ifdef UART_ECHO_SCHED_CRLF_EN
        chk("cr_lf", 32'(sent_q[1]), 32'h0A);
        chk("cr_host", 32'(sent_q[2]), 32'h77);
`else
        chk("cr_host", 32'(sent_q[1]), 32'h77);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_echo_sched.md
# uart_echo_sched

Transmit-side scheduler for the IceStick UART echo design. It sits between `uart_rx`, a host-side byte request port and a single `uart_tx` instance. Received bytes are buffered in a small FIFO and shared fairly with host requests on the one transmitter, so the serial line is never double-driven and no byte is issued while a frame is in flight.

## Interface
- `FIFO_DEPTH`, 8: echo FIFO entries; must be a power of two, ≥ 2.
- `hwclk`  in  1  system clock (12 MHz on IceStick, 104 clocks per bit at 115200 baud).
- `rst`  in  1  reset; synchronous and active-high.
- `rx_dv`  in  1  one-cycle strobe from `uart_rx`: `rx_byte` is valid.
- `rx_byte`  in  8  received byte.
- `req_valid`  in  1  host has a byte to send; held until accepted.
- `req_byte`  in  8  host byte; stable while `req_valid` is high.
- `req_ready`  out  1  one-cycle pulse: host byte accepted, i.e. issued to `uart_tx`.
- `tx_dv`  out  1  one-cycle start strobe to `uart_tx`.
- `tx_byte`  out  8  byte for `uart_tx`; registered, held until the next issue.
- `tx_active`  in  1  `uart_tx` busy.
- `tx_done`  in  1  one-cycle pulse from `uart_tx` at the end of the stop bit.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  current echo FIFO occupancy.
- `overflow`  out  1  sticky flag: an `rx_dv` byte was dropped.

## Operation
- FSM states: IDLE, LOAD, BUSY.
- IDLE:
  - Waits until `tx_active` = 0 and at least one source is pending.
  - Pending sources are the FIFO not empty, `req_valid`, or a pending LF (see Configuration).
  - On grant, latches `tx_byte`, pops the FIFO or pulses `req_ready` if applicable, then moves to LOAD.
- LOAD: `tx_dv` = 1 for exactly this cycle, then BUSY.
- BUSY: waits for `tx_done`, then IDLE. Stray `tx_done` pulses seen in IDLE or LOAD are ignored.
- Arbitration:
  - A pending LF wins outright.
  - Otherwise round-robin between FIFO and host, tracked by a `last_grant` bit (reset value: host).
  - With both sources pending after reset, the FIFO is served first.
  - A single pending source is served regardless of `last_grant`.
- FIFO push rules:
  - Push on `rx_dv` is accepted when count < FIFO_DEPTH, or when the FIFO pops in the same cycle.
  - Simultaneous push and pop leaves the count unchanged.
  - A push on a full FIFO with no pop is dropped and sets `overflow`. The flag clears only on `rst`.
- Pointers wrap modulo FIFO_DEPTH. `fifo_count` ranges 0..FIFO_DEPTH.
- Host bytes are never dropped: `req_valid` simply waits.

## Timing
- Reset values: `tx_dv` = 0, `tx_byte` = 0x00, `req_ready` = 0, `fifo_count` = 0, `overflow` = 0. FSM goes to IDLE, FIFO is emptied, pending LF is cleared, `last_grant` is set to host.
- Reset mid-frame: the block returns to IDLE and issues nothing until `tx_active` has dropped.
- Echo latency: with the line idle, `rx_dv` in cycle N gives `fifo_count` = 1 in N+1 and `tx_dv` high in cycle N+2.
- Host latency: `req_valid` rising in cycle N, with an idle line and no competing source, gives `req_ready` in N+1 and `tx_dv` in N+2.
- Back-to-back issue: `tx_done` in cycle M gives IDLE in M+1 and the next `tx_dv` at M+2 at the earliest.
- `tx_byte` is valid from the cycle `tx_dv` rises and is held until the next grant.

## Configuration
- `UART_ECHO_SCHED_CRLF_EN` defined:
  - When an echoed FIFO byte equals 0x0D, a pending LF is set.
  - The next grant transmits 0x0A ahead of any other source and does not change `last_grant`.
  - Host 0x0D bytes do not trigger this.
- Macro undefined: the pending-LF logic is absent and bytes are echoed verbatim.

## Structure
- Shared package `uart_pkg`:
  - FSM state enum (IDLE/LOAD/BUSY).
  - ASCII constants `ASCII_CR` = 8'h0D and `ASCII_LF` = 8'h0A.
  - `UART_CLKS_PER_BIT` = 104.
- One sub-module: `sync_fifo`, parameterised width and depth, with push/pop/full/empty/count outputs. The scheduler holds only the FSM, the arbiter and the overflow flag.

## Test plan
- Single echo: send 0x41 over `ftdi_rx`. Expect `tx_dv` at `rx_dv`+2 with `tx_byte` = 0x41, and exactly one 1040-clock frame on `ftdi_tx`.
- Contention after reset: FIFO holds 0x01, `req_valid` with 0x02. Expect frames issued in the order 0x01, 0x02, then host and FIFO alternating while both stay pending.
- Overflow: hold `tx_active` high and inject 9 `rx_dv` bytes with FIFO_DEPTH = 8. Expect `fifo_count` = 8 and `overflow` = 1. On releasing `tx_active`, the first 8 bytes are sent in order.
- Push and pop in the same cycle on a full FIFO: the push is accepted, `fifo_count` stays 8 and `overflow` stays 0.
- Reset mid-frame: assert `rst` for 1 cycle while in BUSY with 3 bytes queued. Expect all outputs at their reset values, `fifo_count` = 0, and no `tx_dv` until `tx_active` is low.
- CRLF (macro defined): echo 0x0D with `req_valid` pending. Expect the sequence 0x0D, 0x0A, host byte. With the macro undefined, expect 0x0D followed by the host byte.
